// File: rtl/muldiv_defs.sv
// ----------------------------------------------------------------------------
// muldiv_defs
// Shared definitions for the multiply/divide sequencer.
//   ALU_MULT / ALU_DIV : operation codes as produced by the ALU control decode.
//   S_IDLE / S_MUL / S_DIV : sequencer state encodings.
// ----------------------------------------------------------------------------
package muldiv_defs;

    localparam logic [3:0] ALU_MULT = 4'b0101;
    localparam logic [3:0] ALU_DIV  = 4'b1011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

endpackage : muldiv_defs

// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) unit that
// produces a 64-bit result in HI/LO, one bit per clock.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   request strobe, sampled every rising edge
//   ALU_Control in   operation code (ALU_MULT or ALU_DIV accepted)
//   A           in   multiplicand / dividend
//   B           in   multiplier / divisor
//   busy        out  operation in progress (stall request)
//   done        out  one-cycle completion pulse
//   Hi          out  mult: upper product, div: remainder
//   Lo          out  mult: lower product, div: quotient
//   div_by_zero out  set when the last divide had a zero divisor
// ----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q,   cnt_d;
    // Multiply: {upper, lower} partial product, lower half starts as B.
    // Divide:   {remainder, quotient}, quotient half starts as A.
    logic [2*WIDTH-1:0] acc_q,   acc_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]   opnd_q,  opnd_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               dbz_q,   dbz_d;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic               last_iter;
    logic               req_ok;

    always_comb begin
        // Add the multiplicand into the upper half with carry, then shift the
        // whole accumulator right; the carry becomes the new MSB.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Shift {rem, quot} left; the shifted remainder needs one extra bit
        // before the compare so no dividend bit is lost.
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, opnd_q};
        div_ge   = (rem_sh >= {1'b0, opnd_q});
        div_next = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], div_ge};

        last_iter = (cnt_q == CW'(WIDTH - 1));
        req_ok    = start && ((ALU_Control == ALU_MULT) || (ALU_Control == ALU_DIV));
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    busy_d = 1'b1;
                    dbz_d  = 1'b0;
                    cnt_d  = '0;
                    if (ALU_Control == ALU_MULT) begin
                        state_d = S_MUL;
                        opnd_d  = A;
                        acc_d   = {{WIDTH{1'b0}}, B};
                    end else begin
                        state_d = S_DIV;
                        opnd_d  = B;
                        acc_d   = {{WIDTH{1'b0}}, A};
                    end
                end
            end

            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    lo_d    = mul_next[WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_DIV: begin
                if (opnd_q == '0) begin
                    // Zero divisor: finish at once with the dividend as the
                    // remainder and an all-ones quotient.
                    hi_d    = acc_q[WIDTH-1:0];
                    lo_d    = '1;
                    dbz_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        hi_d    = div_next[2*WIDTH-1:WIDTH];
                        lo_d    = div_next[WIDTH-1:0];
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign Hi          = hi_q;
    assign Lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Expected results come from plain
// 64-bit arithmetic (a*b, a/b, a%b) plus the zero-divisor rule; latency and
// busy duration are checked against the cycle counts of the operation.
// Inputs change and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [3:0] C_MULT = 4'b0101;
    localparam logic [3:0] C_DIV  = 4'b1011;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    alu_control;
    logic [W-1:0]  a_in, b_in;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    // Last completed result as seen by software (Hi/Lo must hold it).
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dbz = 1'b0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ALU_Control (alu_control),
        .A           (a_in),
        .B           (b_in),
        .busy        (busy),
        .done        (done),
        .Hi          (hi),
        .Lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request at the current falling edge and follow it to done.
    // poke_at >= 0 re-asserts start (with a DIV 1/1) at that cycle while busy.
    task automatic run_op(input string tag, input logic [3:0] code,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at);
        logic [63:0]  prod;
        logic [W-1:0] n_hi, n_lo;
        logic         n_dbz;
        int           lat, cycles, busy_cnt;
        bit           held, overlap;

        if (code == C_MULT) begin
            prod  = 64'(a) * 64'(b);
            n_hi  = prod[63:32];
            n_lo  = prod[31:0];
            n_dbz = 1'b0;
            lat   = W;
        end else if (b == '0) begin
            n_hi  = a;
            n_lo  = '1;
            n_dbz = 1'b1;
            lat   = 1;
        end else begin
            n_hi  = a % b;
            n_lo  = a / b;
            n_dbz = 1'b0;
            lat   = W;
        end

        start       = 1'b1;
        alu_control = code;
        a_in        = a;
        b_in        = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = $urandom;   // operands must have been latched
        b_in  = $urandom;
        check({tag, ".busy_after_accept"}, busy, 1);
        check({tag, ".done_after_accept"}, done, 0);

        cycles   = 0;
        busy_cnt = 0;
        held     = 1'b1;
        overlap  = 1'b0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (hi !== exp_hi || lo !== exp_lo) held = 1'b0;
            if (busy && done) overlap = 1'b1;
            start = (cycles == poke_at);
            if (cycles == poke_at) begin
                alu_control = C_DIV;
                a_in = 32'd1;
                b_in = 32'd1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;

        check({tag, ".latency"}, cycles, lat);
        check({tag, ".busy_cycles"}, busy_cnt, lat);
        check({tag, ".hold_hilo"}, held, 1);
        check({tag, ".no_overlap"}, overlap || (busy && done), 0);
        check({tag, ".hi"}, hi, n_hi);
        check({tag, ".lo"}, lo, n_lo);
        check({tag, ".dbz"}, div_by_zero, n_dbz);
        exp_hi  = n_hi;
        exp_lo  = n_lo;
        exp_dbz = n_dbz;
    endtask

    // One quiet cycle: done must have been a single-cycle pulse.
    task automatic idle(input string tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".idle_dbz"}, div_by_zero, exp_dbz);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        alu_control = 4'b0;
        a_in        = '0;
        b_in        = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.hi", hi, 0);
        check("reset.lo", lo, 0);
        check("reset.dbz", div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("mul7x6", C_MULT, 32'd7, 32'd6, -1);
        idle("mul7x6");
        run_op("mulmax", C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        idle("mulmax");
        run_op("div100_7", C_DIV, 32'd100, 32'd7, -1);
        idle("div100_7");
        run_op("div5_9", C_DIV, 32'd5, 32'd9, -1);
        idle("div5_9");
        run_op("div5_0", C_DIV, 32'd5, 32'd0, -1);
        idle("div5_0");

        // Unsupported code is ignored
        start       = 1'b1;
        alu_control = 4'b0010;
        a_in        = 32'd3;
        b_in        = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("badcode.busy", busy, 0);
        check("badcode.done", done, 0);
        check("badcode.hi", hi, exp_hi);
        check("badcode.lo", lo, exp_lo);
        check("badcode.dbz", div_by_zero, exp_dbz);

        // Start while busy is ignored
        run_op("mul_poke", C_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        idle("mul_poke");

        // Reset in the middle of a multiply
        start       = 1'b1;
        alu_control = C_MULT;
        a_in        = 32'hDEAD_BEEF;
        b_in        = 32'h0000_0101;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midreset.busy_before", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset.busy", busy, 0);
        check("midreset.done", done, 0);
        check("midreset.hi", hi, 0);
        check("midreset.lo", lo, 0);
        check("midreset.dbz", div_by_zero, 0);
        reset   = 1'b0;
        exp_hi  = '0;
        exp_lo  = '0;
        exp_dbz = 1'b0;
        @(negedge clk);

        // Back-to-back: second start lands in the done cycle
        run_op("b2b_div", C_DIV, 32'd100, 32'd7, -1);
        run_op("b2b_mul", C_MULT, 32'd3, 32'd4, -1);
        idle("b2b_mul");

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            logic [3:0]   code;
            logic [W-1:0] ra, rb;
            code = ($urandom_range(0, 1) == 0) ? C_MULT : C_DIV;
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            run_op($sformatf("rand%0d", i), code, ra, rb, -1);
            if ($urandom_range(0, 1) == 0) idle($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_muldiv_sequencer
